// File: rtl/pixel_compositor_pkg.sv
// Shared constants for the VGA output stage: sync idle levels, default key colour
// and per-stage pipeline latencies that callers sum to produce base_dly.
package pixel_compositor_pkg;

  localparam logic        SYNC_IDLE_DEFAULT = 1'b1;
  localparam logic [23:0] KEY_DEFAULT       = 24'hFFFFFF;

  // Bit positions of the timing bundle carried through the sync delay line
  localparam int SYNC_W     = 3;
  localparam int SYNC_BLANK = 0;
  localparam int SYNC_HSYNC = 1;
  localparam int SYNC_VSYNC = 2;

  localparam int LAT_SCALER  = 2;
  localparam int LAT_FILTER  = 3;
  localparam int LAT_ENHANCE = 4;

  function automatic int base_latency(input logic use_filter, input logic use_enhance);
    return LAT_SCALER + (use_filter ? LAT_FILTER : 0) + (use_enhance ? LAT_ENHANCE : 0);
  endfunction

endpackage

// File: rtl/pixel_compositor_sync_delay_line.sv
// Fixed-depth shift register for the timing bundle with a runtime output tap and a
// one-bit look-ahead tap showing what a given tap will present after the next edge.
module sync_delay_line #(
  parameter int               WIDTH    = 3,
  parameter int               DEPTH    = 32,
  parameter int               TAP_W    = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] IDLE     = '1,
  parameter int               PEEK_BIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAP_W-1:0] i_tap,
  input  logic [TAP_W-1:0] i_peek_tap,
  output logic [WIDTH-1:0] o_data,
  output logic             o_peek
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) r_stage[k] <= IDLE;
    end else begin
      r_stage[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign o_data = r_stage[i_tap];

  // After the edge, tap n holds what stage n-1 (or the input, for n=0) holds now
  assign o_peek = (i_peek_tap == '0) ? i_data[PEEK_BIT]
                                     : r_stage[i_peek_tap - 1'b1][PEEK_BIT];

endmodule

// File: rtl/pixel_compositor.sv
// Priority overlay compositor with frame-synchronous shadow configuration and a
// runtime-selectable sync realignment delay matched to the base pixel latency.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int   NUM_LAYERS = 4,
  parameter int   PIX_W      = 24,
  parameter int   MAX_DLY    = 32,
  parameter int   DLY_W      = 6,
  parameter logic SYNC_IDLE  = SYNC_IDLE_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic                        blank,
  input  logic [PIX_W-1:0]            base_pixel,
  input  logic [DLY_W-1:0]            base_dly,
  input  logic [NUM_LAYERS*PIX_W-1:0] layer_pixel,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [PIX_W-1:0]            key_color,
  input  logic                        force_black,
  output logic [PIX_W-1:0]            pixel_out,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic                        blank_out,
  output logic                        dly_err
);

  localparam int               TAP_W   = $clog2(MAX_DLY);
  localparam logic [DLY_W-1:0] MAX_TAP = DLY_W'(MAX_DLY - 1);
  localparam logic [SYNC_W-1:0] SYNC_RST = {SYNC_IDLE, SYNC_IDLE, 1'b1};

  logic                  r_vsync_q;
  logic [TAP_W-1:0]      r_act_dly;
  logic [NUM_LAYERS-1:0] r_act_en;
  logic [PIX_W-1:0]      r_act_key;
  logic                  r_dly_err;
  logic [PIX_W-1:0]      r_pixel;

  logic                  w_frame_start;
  logic                  w_dly_over;
  logic [TAP_W-1:0]      w_dly_clamp;
  logic [TAP_W-1:0]      w_dly_next;
  logic [SYNC_W-1:0]     w_sync_tap;
  logic                  w_blank_next;
  logic [PIX_W-1:0]      w_sel_pixel;
  logic [PIX_W-1:0]      w_layer [NUM_LAYERS];

  assign w_frame_start = vsync & ~r_vsync_q;
  assign w_dly_over    = base_dly > MAX_TAP;
  assign w_dly_clamp   = w_dly_over ? MAX_TAP[TAP_W-1:0] : base_dly[TAP_W-1:0];
  assign w_dly_next    = w_frame_start ? w_dly_clamp : r_act_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync_q <= SYNC_IDLE;
      r_act_dly <= '0;
      r_act_en  <= '0;
      r_act_key <= '1;
      r_dly_err <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (w_frame_start) begin
        r_act_dly <= w_dly_clamp;
        r_act_en  <= layer_en;
        r_act_key <= key_color;
        r_dly_err <= w_dly_over;
      end
    end
  end

  sync_delay_line #(
    .WIDTH   (SYNC_W),
    .DEPTH   (MAX_DLY),
    .TAP_W   (TAP_W),
    .IDLE    (SYNC_RST),
    .PEEK_BIT(SYNC_BLANK)
  ) u_sync_dly (
    .clk       (clk),
    .reset     (reset),
    .i_data    ({vsync, hsync, blank}),
    .i_tap     (r_act_dly),
    .i_peek_tap(w_dly_next),
    .o_data    (w_sync_tap),
    .o_peek    (w_blank_next)
  );

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      assign w_layer[gi] = layer_pixel[gi*PIX_W +: PIX_W];
    end
  endgenerate

  // Walk from lowest priority upward so the highest-priority opaque layer wins
  always_comb begin
    w_sel_pixel = base_pixel;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (r_act_en[i] && (w_layer[i] != r_act_key)) w_sel_pixel = w_layer[i];
    end
  end

  // Blank is taken from the value the tap presents alongside this pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pixel <= '0;
    else       r_pixel <= (force_black || w_blank_next) ? '0 : w_sel_pixel;
  end

  assign pixel_out = r_pixel;
  assign vsync_out = w_sync_tap[SYNC_VSYNC];
  assign hsync_out = w_sync_tap[SYNC_HSYNC];
  assign blank_out = w_sync_tap[SYNC_BLANK];
  assign dly_err   = r_dly_err;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: per-cycle comparison against a history-based
// reference model plus literal checks of the key latency and priority cases.
module tb_pixel_compositor;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync, blank;
  logic [23:0] base_pixel;
  logic [5:0]  base_dly;
  logic [95:0] layer_pixel;
  logic [3:0]  layer_en;
  logic [23:0] key_color;
  logic        force_black;
  logic [23:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out, dly_err;

  int n_vec = 0;
  int n_err = 0;

  pixel_compositor dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .base_pixel (base_pixel),
    .base_dly   (base_dly),
    .layer_pixel(layer_pixel),
    .layer_en   (layer_en),
    .key_color  (key_color),
    .force_black(force_black),
    .pixel_out  (pixel_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .dly_err    (dly_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc = 0;
  int         epoch = 0;
  logic [2:0] hist [0:8191];
  int         m_dly = 0;
  logic [3:0] m_en = '0;
  logic [23:0] m_key = '1;
  logic       m_err = 1'b0;
  logic       m_vq = 1'b1;

  function automatic logic [2:0] sync_at(input int i);
    if (i < epoch) return 3'b111;
    return hist[i];
  endfunction

  function automatic logic [23:0] compose(input logic [3:0] en, input logic [23:0] key,
                                          input logic [95:0] lay, input logic [23:0] base);
    for (int i = 0; i < 4; i++)
      if (en[i] && lay[i*24 +: 24] != key) return lay[i*24 +: 24];
    return base;
  endfunction

  always @(posedge clk) begin
    logic [23:0] e_pix;
    logic [2:0]  e_sync;
    logic        e_err;
    logic [3:0]  pre_en;
    logic [23:0] pre_key;
    if (reset) begin
      epoch  = cyc + 1;
      m_dly  = 0;
      m_en   = '0;
      m_key  = '1;
      m_err  = 1'b0;
      m_vq   = 1'b1;
      e_pix  = '0;
      e_sync = 3'b111;
      e_err  = 1'b0;
    end else begin
      hist[cyc] = {vsync, hsync, blank};
      pre_en  = m_en;
      pre_key = m_key;
      if (vsync && !m_vq) begin
        m_dly = (base_dly > 6'd31) ? 31 : int'(base_dly);
        m_err = base_dly > 6'd31;
        m_en  = layer_en;
        m_key = key_color;
      end
      m_vq   = vsync;
      e_sync = sync_at(cyc - m_dly);
      e_err  = m_err;
      e_pix  = (force_black || e_sync[0]) ? 24'h0 : compose(pre_en, pre_key, layer_pixel, base_pixel);
    end
    cyc++;
    #1;
    chk("pixel_out", {8'h0, pixel_out}, {8'h0, e_pix});
    chk("vsync_out", {31'h0, vsync_out}, {31'h0, e_sync[2]});
    chk("hsync_out", {31'h0, hsync_out}, {31'h0, e_sync[1]});
    chk("blank_out", {31'h0, blank_out}, {31'h0, e_sync[0]});
    chk("dly_err",   {31'h0, dly_err},   {31'h0, e_err});
  end

  // ---------------- stimulus ----------------
  logic       pat_on = 1'b1;
  logic [7:0] pat = 8'h10;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (pat_on) begin
        base_pixel = {pat, pat ^ 8'h5A, ~pat};
        pat = pat + 8'd1;
      end
    end
  endtask

  task automatic frame_start();
    vsync = 1'b0;
    step(2);
    vsync = 1'b1;
    step(1);
  endtask

  task automatic pulse_check(input int d, input string name);
    hsync = 1'b0;
    step(1);
    hsync = 1'b1;
    repeat (d - 2) @(posedge clk);
    #2 chk({name, "_pre"}, {31'h0, hsync_out}, 32'h1);
    @(posedge clk);
    #2 chk(name, {31'h0, hsync_out}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    hsync       = 1'b1;
    vsync       = 1'b1;
    blank       = 1'b1;
    base_pixel  = 24'h0;
    base_dly    = 6'd0;
    layer_pixel = {24'hABCDEF, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
    layer_en    = 4'b0000;
    key_color   = 24'hFFFFFF;
    force_black = 1'b0;

    step(3);
    chk("rst_pix",   {8'h0, pixel_out}, 32'h0);
    chk("rst_blank", {31'h0, blank_out}, 32'h1);
    chk("rst_hsync", {31'h0, hsync_out}, 32'h1);
    chk("rst_err",   {31'h0, dly_err},   32'h0);
    reset = 1'b0;

    blank    = 1'b0;
    base_dly = 6'd5;
    frame_start();
    step(40);
    pulse_check(6, "dly5");

    pat_on     = 1'b0;
    base_pixel = 24'h123456;
    layer_en   = 4'b0011;
    frame_start();
    step(3);
    @(posedge clk);
    #2 chk("ovl_l1", {8'h0, pixel_out}, 32'h0000FF);
    @(negedge clk);
    layer_pixel[0 +: 24] = 24'hFF0000;
    @(posedge clk);
    #2 chk("ovl_l0", {8'h0, pixel_out}, 32'hFF0000);

    @(negedge clk);
    force_black = 1'b1;
    @(posedge clk);
    #2 chk("force_black", {8'h0, pixel_out}, 32'h0);
    @(negedge clk);
    force_black = 1'b0;
    @(posedge clk);
    #2 chk("force_release", {8'h0, pixel_out}, 32'hFF0000);

    @(negedge clk);
    blank = 1'b1;
    step(8);
    @(posedge clk);
    #2 chk("blank_pix", {8'h0, pixel_out}, 32'h0);
    chk("blank_out", {31'h0, blank_out}, 32'h1);
    @(negedge clk);
    blank = 1'b0;
    step(8);

    pat_on   = 1'b1;
    base_dly = 6'd10;
    step(5);
    pulse_check(6, "mid_frame_dly");
    frame_start();
    step(40);
    pulse_check(11, "dly10");

    base_dly = 6'd40;
    frame_start();
    step(40);
    chk("err_set", {31'h0, dly_err}, 32'h1);
    pulse_check(32, "dly_clamp");
    base_dly = 6'd3;
    frame_start();
    step(5);
    chk("err_clr", {31'h0, dly_err}, 32'h0);
    pulse_check(4, "dly3");

    base_dly = 6'd40;
    frame_start();
    step(3);
    chk("err_set2", {31'h0, dly_err}, 32'h1);
    pat_on     = 1'b0;
    base_pixel = 24'h123456;
    step(2);
    chk("pre_reset", {8'h0, pixel_out}, 32'hFF0000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_pix",   {8'h0, pixel_out}, 32'h0);
    chk("mid_rst_blank", {31'h0, blank_out}, 32'h1);
    chk("mid_rst_hsync", {31'h0, hsync_out}, 32'h1);
    chk("mid_rst_vsync", {31'h0, vsync_out}, 32'h1);
    chk("mid_rst_err",   {31'h0, dly_err},   32'h0);
    step(2);
    reset = 1'b0;
    step(5);
    chk("post_rst_base", {8'h0, pixel_out}, 32'h123456);
    chk("post_rst_err",  {31'h0, dly_err},  32'h0);

    pat_on   = 1'b1;
    base_dly = 6'd2;
    frame_start();
    step(10);
    pulse_check(3, "dly2");
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
